// File: rtl/fpdiv_core_pkg.sv
// Shared constants and FSM state type for the FP divide significand/exponent core.
package fpdiv_core_pkg;

  // Default exponent width (2's complement) and exponent bias of the FP format.
  localparam int unsigned WEXPSUM = 10;
  localparam int unsigned BIAS    = 127;

  // Divider control states; encodings are fixed so they match the rest of the FP path.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } fpdiv_state_e;

endpackage

// File: rtl/fpdiv_exponent.sv
// Combinational exponent-difference stage of the divide path: the counterpart of
// the multiplier's exponent-sum stage. Result wraps modulo 2^WEXPSUM; range
// checking is left to the downstream rounder.
module fpdiv_exponent
  import fpdiv_core_pkg::*;
#(
  parameter int unsigned WEXPSUM = fpdiv_core_pkg::WEXPSUM,
  parameter int unsigned BIAS    = fpdiv_core_pkg::BIAS
) (
  input  logic [WEXPSUM-1:0] expa,
  input  logic [WEXPSUM-1:0] expb,
  input  logic               lessthanone,
  output logic [WEXPSUM-1:0] expdiff,
  output logic               tiny
);

  localparam logic [WEXPSUM-1:0] BIAS_V = WEXPSUM'(BIAS);

  // expdiff = expa - expb + BIAS - lessthanone; tiny flags zero or negative results.
  always_comb begin
    expdiff = expa - expb + BIAS_V - {{(WEXPSUM-1){1'b0}}, lessthanone};
    tiny    = ~|expdiff[WEXPSUM-2:0] | expdiff[WEXPSUM-1];
  end

endmodule

// File: rtl/fpdiv_core.sv
// Iterative restoring significand divider with exponent-difference unit.
// One quotient bit retires per clock; WSIG+2 quotient bits are developed so the
// result can be normalized by at most one place and still keep a guard bit.
module fpdiv_core
  import fpdiv_core_pkg::*;
#(
  parameter int unsigned WSIG    = 24,
  parameter int unsigned WEXPSUM = fpdiv_core_pkg::WEXPSUM,
  parameter int unsigned BIAS    = fpdiv_core_pkg::BIAS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WSIG-1:0]    ma,
  input  logic [WSIG-1:0]    mb,
  input  logic [WEXPSUM-1:0] expa,
  input  logic [WEXPSUM-1:0] expb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WSIG-1:0]    mant,
  output logic               guard,
  output logic               sticky,
  output logic [WEXPSUM-1:0] expdiff,
  output logic               tiny,
  output logic               divzero
);

  localparam int unsigned QW = WSIG + 2;
  localparam int unsigned CW = $clog2(WSIG + 3);
  localparam logic [CW-1:0] LAST_CNT = CW'(WSIG + 2);

  fpdiv_state_e        state_q, state_d;
  logic [WSIG-1:0]     mb_q, mb_d;
  logic [WEXPSUM-1:0]  expa_q, expa_d;
  logic [WEXPSUM-1:0]  expb_q, expb_d;
  logic [WSIG:0]       rem_q, rem_d;
  logic [QW-1:0]       quo_q, quo_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WSIG-1:0]     mant_q, mant_d;
  logic                guard_q, guard_d;
  logic                sticky_q, sticky_d;
  logic [WEXPSUM-1:0]  expdiff_q, expdiff_d;
  logic                tiny_q, tiny_d;
  logic                divzero_q, divzero_d;

  logic [WSIG:0]       diff;
  logic [WSIG:0]       keep;
  logic                lessthanone;
  logic [WEXPSUM-1:0]  exp_c;
  logic                tiny_c;

  // Quotient below one needs a one-place normalize; a zero divisor never normalizes.
  always_comb begin
    lessthanone = mb_q[WSIG-1] ? ~quo_q[QW-1] : 1'b0;
  end

  fpdiv_exponent #(
    .WEXPSUM (WEXPSUM),
    .BIAS    (BIAS)
  ) u_exponent (
    .expa        (expa_q),
    .expb        (expb_q),
    .lessthanone (lessthanone),
    .expdiff     (exp_c),
    .tiny        (tiny_c)
  );

  // Trial subtraction: the top bit of the WSIG+1-bit difference is the borrow.
  always_comb begin
    diff = rem_q - {1'b0, mb_q};
    keep = diff[WSIG] ? rem_q : diff;
  end

  // Next-state logic for the FSM, datapath shift registers and result registers.
  // The divisor check happens on the first DIV cycle (operands already registered),
  // which gives the zero-divisor path one cycle of latency and the normal path
  // WSIG+3 cycles: WSIG+2 iterations plus the normalize/commit cycle.
  always_comb begin
    state_d   = state_q;
    mb_d      = mb_q;
    expa_d    = expa_q;
    expb_d    = expb_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    mant_d    = mant_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    expdiff_d = expdiff_q;
    tiny_d    = tiny_q;
    divzero_d = divzero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_DIV;
          mb_d    = mb;
          expa_d  = expa;
          expb_d  = expb;
          rem_d   = {1'b0, ma};
          quo_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_DIV: begin
        if (!mb_q[WSIG-1]) begin
          state_d   = ST_DONE;
          mant_d    = '1;
          guard_d   = 1'b0;
          sticky_d  = 1'b0;
          expdiff_d = exp_c;
          tiny_d    = tiny_c;
          divzero_d = 1'b1;
        end else if (cnt_q == LAST_CNT) begin
          state_d   = ST_DONE;
          divzero_d = 1'b0;
          expdiff_d = exp_c;
          tiny_d    = tiny_c;
          if (quo_q[QW-1]) begin
            mant_d   = quo_q[QW-1:2];
            guard_d  = quo_q[1];
            sticky_d = quo_q[0] | (|rem_q);
          end else begin
            mant_d   = quo_q[QW-2:1];
            guard_d  = quo_q[0];
            sticky_d = |rem_q;
          end
        end else begin
          quo_d = {quo_q[QW-2:0], ~diff[WSIG]};
          rem_d = {keep[WSIG-1:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mb_q      <= '0;
      expa_q    <= '0;
      expb_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      mant_q    <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      expdiff_q <= '0;
      tiny_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mb_q      <= mb_d;
      expa_q    <= expa_d;
      expb_q    <= expb_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      mant_q    <= mant_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      expdiff_q <= expdiff_d;
      tiny_q    <= tiny_d;
      divzero_q <= divzero_d;
    end
  end

  // Handshake flags decode directly from the state register.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    mant      = mant_q;
    guard     = guard_q;
    sticky    = sticky_q;
    expdiff   = expdiff_q;
    tiny      = tiny_q;
    divzero   = divzero_q;
  end

endmodule

// File: tb/tb_fpdiv_core.sv
// Directed bench for fpdiv_core: table of hand-computed divide vectors plus
// hand-written sequences for output hold/back-pressure and mid-divide reset.
module tb_fpdiv_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] ma, mb;
  logic [9:0]  expa, expb;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] mant;
  logic        guard, sticky;
  logic [9:0]  expdiff;
  logic        tiny, divzero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpdiv_core #(
    .WSIG    (24),
    .WEXPSUM (10),
    .BIAS    (127)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ma        (ma),
    .mb        (mb),
    .expa      (expa),
    .expb      (expb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant      (mant),
    .guard     (guard),
    .sticky    (sticky),
    .expdiff   (expdiff),
    .tiny      (tiny),
    .divzero   (divzero)
  );

  typedef struct {
    logic [23:0] ma;
    logic [23:0] mb;
    logic [9:0]  expa;
    logic [9:0]  expb;
    logic [23:0] mant;
    logic        guard;
    logic        sticky;
    logic [9:0]  expdiff;
    logic        tiny;
    logic        divzero;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [23:0] a, input logic [23:0] b,
                              input logic [9:0] ea, input logic [9:0] eb,
                              input logic [23:0] m, input logic g, input logic s,
                              input logic [9:0] ed, input logic t, input logic dz,
                              input int l);
    vec_t v;
    v.ma = a; v.mb = b; v.expa = ea; v.expb = eb;
    v.mant = m; v.guard = g; v.sticky = s; v.expdiff = ed;
    v.tiny = t; v.divzero = dz; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Present an operand in IDLE, then count edges after acceptance until out_valid.
  task automatic run_op(input vec_t v, output int lat);
    @(negedge clk);
    chk("in_ready_before_op", {63'd0, in_ready}, 64'd1);
    ma = v.ma; mb = v.mb; expa = v.expa; expb = v.expb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat);
    chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
    chk({tag, "_mant"},    64'(mant),    64'(v.mant));
    chk({tag, "_guard"},   64'(guard),   64'(v.guard));
    chk({tag, "_sticky"},  64'(sticky),  64'(v.sticky));
    chk({tag, "_expdiff"}, 64'(expdiff), 64'(v.expdiff));
    chk({tag, "_tiny"},    64'(tiny),    64'(v.tiny));
    chk({tag, "_divzero"}, 64'(divzero), 64'(v.divzero));
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_in_ready_back"},  {63'd0, in_ready},  64'd1);
  endtask

  initial begin : main
    int   lat;
    vec_t v;
    vec_t one_one;
    logic [63:0] held;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ma = '0; mb = '0; expa = '0; expb = '0;

    // ma, mb, expa, expb -> mant, guard, sticky, expdiff, tiny, divzero, latency
    vecs.push_back(mk(24'h800000, 24'h800000, 10'd127, 10'd127, 24'h800000, 0, 0, 10'd127, 0, 0, 27));
    vecs.push_back(mk(24'h800000, 24'hC00000, 10'd127, 10'd127, 24'hAAAAAA, 1, 1, 10'd126, 0, 0, 27));
    vecs.push_back(mk(24'h800000, 24'hC00000, 10'd1,   10'd127, 24'hAAAAAA, 1, 1, 10'd0,   1, 0, 27));
    vecs.push_back(mk(24'hABCDEF, 24'hABCDEF, 10'd5,   10'd200, 24'h800000, 0, 0, 10'h3BC, 1, 0, 27));
    vecs.push_back(mk(24'h800000, 24'h000000, 10'd127, 10'd127, 24'hFFFFFF, 0, 0, 10'd127, 0, 1, 1));
    vecs.push_back(mk(24'h800000, 24'h7FFFFF, 10'd10,  10'd20,  24'hFFFFFF, 0, 0, 10'd117, 0, 1, 1));
    vecs.push_back(mk(24'hFFFFFF, 24'h800000, 10'd130, 10'd120, 24'hFFFFFF, 0, 0, 10'd137, 0, 0, 27));
    vecs.push_back(mk(24'h800000, 24'hFFFFFF, 10'h3FF, 10'd1,   24'h800000, 1, 1, 10'd124, 0, 0, 27));
    vecs.push_back(mk(24'hC00000, 24'h800000, 10'd127, 10'd127, 24'hC00000, 0, 0, 10'd127, 0, 0, 27));
    vecs.push_back(mk(24'h900000, 24'h900000, 10'h1FF, 10'h200, 24'h800000, 0, 0, 10'd126, 0, 0, 27));
    vecs.push_back(mk(24'h800000, 24'h800000, 10'd1,   10'd127, 24'h800000, 0, 0, 10'd1,   0, 0, 27));
    vecs.push_back(mk(24'h800000, 24'h800000, 10'd385, 10'd0,   24'h800000, 0, 0, 10'h200, 1, 0, 27));
    one_one = vecs[0];

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_outputs", {mant, guard, sticky, expdiff, tiny, divzero}, 64'd0);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i], lat);
      check_result($sformatf("vec%0d", i), vecs[i], lat);
      release_result($sformatf("vec%0d", i));
    end

    // Back-pressure: result held for 10 cycles while a new operand waits on in_valid
    v = vecs[1];
    run_op(v, lat);
    check_result("hold_first", v, lat);
    held = {26'd0, v.mant, v.guard, v.sticky, v.expdiff, v.tiny, v.divzero};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ma = 24'hC00000; mb = 24'h800000; expa = 10'd127; expb = 10'd127;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("hold_outputs_c%0d", c),
          {26'd0, mant, guard, sticky, expdiff, tiny, divzero}, held);
      chk($sformatf("hold_in_ready_c%0d", c),  {63'd0, in_ready},  64'd0);
      chk($sformatf("hold_out_valid_c%0d", c), {63'd0, out_valid}, 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;          // handshake edge -> IDLE
    out_ready = 1'b0;
    chk("hold_release_out_valid", {63'd0, out_valid}, 64'd0);
    chk("hold_release_in_ready",  {63'd0, in_ready},  64'd1);
    @(posedge clk); #1;          // waiting operand accepted here
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_result("hold_next", vecs[8], lat);
    release_result("hold_next");

    // Reset at DIV iteration 5, then a clean 1.0/1.0
    @(negedge clk);
    ma = 24'h800000; mb = 24'hC00000; expa = 10'd127; expb = 10'd127;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("middiv_busy", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("middiv_rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("middiv_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("middiv_rst_outputs", {mant, guard, sticky, expdiff, tiny, divzero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(one_one, lat);
    check_result("after_rst", one_one, lat);
    release_result("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
